// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - byte-stream instruction-memory loader
// Assembles big-endian 32-bit words from a byte stream and writes them to instruction memory.
module inst_loader #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       len_words,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_W+1:0] MEM_LIMIT = (ADDR_W+2)'(MEM_BYTES);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       len;
  logic [15:0]       word_cnt;
  logic [1:0]        byte_cnt;
  logic [31:0]       word;
  logic              rst_released;

  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W+1:0] end_addr;

  // Range check is done two bits wider than the address so a load near the top cannot wrap.
  assign start_addr = base_addr & ~(ADDR_W'(3));
  assign end_addr   = {2'b00, start_addr} + {{(ADDR_W-16){1'b0}}, len_words, 2'b00};

  assign cpu_hold = !rst_released || busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      addr         <= '0;
      len          <= '0;
      word_cnt     <= '0;
      byte_cnt     <= '0;
      word         <= '0;
      rst_released <= 1'b0;
      s_ready      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      checksum     <= '0;
    end else begin
      rst_released <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            addr     <= start_addr;
            len      <= len_words;
            word_cnt <= '0;
            byte_cnt <= '0;
            checksum <= '0;
            busy     <= 1'b1;
            if (end_addr > MEM_LIMIT) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              err <= 1'b0;
              if (len_words == 16'd0) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                s_ready <= 1'b1;
                state   <= RECV;
              end
            end
          end
        end
        RECV: begin
          // s_ready is held high for the whole of RECV, so s_valid alone marks a transfer.
          if (s_valid) begin
            byte_cnt                     <= byte_cnt + 2'd1;
            word[{~byte_cnt, 3'b000} +: 8] <= s_data;
            if (byte_cnt == 2'd3) begin
              s_ready   <= 1'b0;
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= {word[31:8], s_data};
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          mem_we   <= 1'b0;
          addr     <= addr + ADDR_W'(4);
          word_cnt <= word_cnt + 16'd1;
          checksum <= checksum + mem_wdata;
          if (word_cnt + 16'd1 == len) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            s_ready <= 1'b1;
            state   <= RECV;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
